// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencer that feeds an overlapping serial pattern matcher.
// It reports a hit pulse on every match, a per-word hit count and a saturating running total.
module pattern_scan_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CFG_WE,
  input  logic [PAT_MAX-1:0] CFG_PAT,
  input  logic [LEN_W-1:0]   CFG_LEN,
  input  logic               IN_VALID,
  input  logic [WORD_W-1:0]  IN_DATA,
  output logic               IN_READY,
  output logic               HIT,
  output logic               DONE,
  output logic [CNT_W-1:0]   WORD_HITS,
  output logic [CNT_W-1:0]   TOTAL_CNT,
  output logic               BUSY
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [LEN_W-1:0] PAT_MAX_L = LEN_W'(PAT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   whits_q, whits_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               hit_q, hit_d;
  logic               done_q, done_d;

  logic [PAT_MAX-1:0] len_mask;
  logic [LEN_W-1:0]   len_clamped;
  logic               match;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // A zero length behaves as a single-bit pattern; anything longer than the history is cut to it.
  always_comb begin
    len_clamped = CFG_LEN;
    if (CFG_LEN == '0) begin
      len_clamped = LEN_W'(1);
    end else if (CFG_LEN > PAT_MAX_L) begin
      len_clamped = PAT_MAX_L;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    whits_d = whits_q;
    total_d = total_q;
    hit_d   = 1'b0;
    done_d  = 1'b0;
    match   = 1'b0;

    case (state_q)
      IDLE: begin
        if (CFG_WE) begin
          pat_d   = CFG_PAT;
          len_d   = len_clamped;
          hist_d  = '0;
          fill_d  = '0;
          total_d = '0;
        end else if (IN_VALID) begin
          word_d  = IN_DATA;
          wcnt_d  = '0;
          idx_d   = IDX_W'(WORD_W - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        hist_d = (hist_q << 1) | PAT_MAX'(word_q[idx_q]);
        if (fill_q != PAT_MAX_L) begin
          fill_d = fill_q + LEN_W'(1);
        end
        match = (((hist_d ^ pat_q) & len_mask) == '0) && (fill_d >= len_q);
        if (match) begin
          hit_d = 1'b1;
          if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + CNT_W'(1);
          if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
        end
        if (idx_q == '0) begin
          state_d = REPORT;
          done_d  = 1'b1;
          whits_d = wcnt_d;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      REPORT: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Length resets to one so that a freshly reset block does not match on every bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      wcnt_q  <= '0;
      whits_q <= '0;
      total_q <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      whits_q <= whits_d;
      total_q <= total_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  assign IN_READY  = (state_q == IDLE) && !CFG_WE && !RESET;
  assign HIT       = hit_q;
  assign DONE      = done_q;
  assign WORD_HITS = whits_q;
  assign TOTAL_CNT = total_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Table-driven bench for pattern_scan_ctrl: expected per-word results are queued at drive time
// and checked by a monitor when DONE fires, plus reset and mid-word reset sequences.
module tb_pattern_scan_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;
  localparam int NVEC    = 11;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              CFG_WE;
  logic [PAT_MAX-1:0] CFG_PAT;
  logic [LEN_W-1:0]  CFG_LEN;
  logic              IN_VALID;
  logic [WORD_W-1:0] IN_DATA;
  logic              IN_READY;
  logic              HIT;
  logic              DONE;
  logic [CNT_W-1:0]  WORD_HITS;
  logic [CNT_W-1:0]  TOTAL_CNT;
  logic              BUSY;

  typedef struct {
    bit               do_cfg;
    bit               with_valid;
    logic [PAT_MAX-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [WORD_W-1:0] word;
    int               hits;
    int               total;
    logic [WORD_W-1:0] mask;
  } vec_t;

  typedef struct {
    int               hits;
    int               total;
    logic [WORD_W-1:0] mask;
  } exp_t;

  vec_t vecs[NVEC];
  exp_t exp_q[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_hs = -1;
  bit have_last = 1'b0;

  int               pos;
  bit               active = 1'b0;
  logic [WORD_W-1:0] hit_mask;

  pattern_scan_ctrl #(
    .WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_PAT(CFG_PAT), .CFG_LEN(CFG_LEN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY), .HIT(HIT), .DONE(DONE),
    .WORD_HITS(WORD_HITS), .TOTAL_CNT(TOTAL_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks the word in flight, collects HIT positions and pops the scoreboard on DONE.
  always @(negedge CLK) begin
    if (RESET) begin
      active = 1'b0;
    end else begin
      checkOutput("in_ready", int'(IN_READY), int'(!BUSY && !CFG_WE));
      if (active) begin
        pos++;
        if (pos >= 1 && pos <= WORD_W) begin
          if (HIT) hit_mask[WORD_W-pos] = 1'b1;
        end else begin
          checkOutput("hit_before_shift", int'(HIT), 0);
        end
        checkOutput("busy", int'(BUSY), 1);
        checkOutput("done_timing", int'(DONE), int'(pos == WORD_W));
        if (pos == WORD_W) begin
          active = 1'b0;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("word_hits", int'(WORD_HITS), e.hits);
            checkOutput("total_cnt", int'(TOTAL_CNT), e.total);
            checkOutput("hit_mask", int'(hit_mask), int'(e.mask));
          end
        end
      end else begin
        checkOutput("idle_hit", int'(HIT), 0);
        checkOutput("idle_done", int'(DONE), 0);
      end
      if (IN_VALID && IN_READY) begin
        active = 1'b1;
        pos = -1;
        hit_mask = '0;
      end
    end
  end

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!BUSY) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    if (!ok) checkOutput("idle_timeout", 1, 0);
  endtask

  task automatic waitHandshake(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (IN_READY) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge CLK); #1;
    end else begin
      checkOutput("handshake_timeout", 1, 0);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit ok;
    if (v.do_cfg) begin
      IN_VALID = 1'b0;
      waitIdle();
      CFG_WE  = 1'b1;
      CFG_PAT = v.pat;
      CFG_LEN = v.len;
      if (v.with_valid) begin
        IN_VALID = 1'b1;
        IN_DATA  = v.word;
        #1;
        checkOutput("cfg_blocks_ready", int'(IN_READY), 0);
      end
      @(posedge CLK); #1;
      CFG_WE = 1'b0;
      if (v.with_valid) checkOutput("cfg_word_not_taken", int'(BUSY), 0);
    end
    IN_DATA  = v.word;
    IN_VALID = 1'b1;
    e.hits  = v.hits;
    e.total = v.total;
    e.mask  = v.mask;
    exp_q.push_back(e);
    waitHandshake(ok);
    if (ok) begin
      if (!v.do_cfg && have_last) checkOutput("hs_period", cyc - last_hs, WORD_W + 2);
      last_hs   = cyc;
      have_last = 1'b1;
    end
  endtask

  task automatic drainQueue();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK); #1;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bit ok;
    vecs[0]  = '{1'b1, 1'b0, 8'h05, 4'd3,  8'hA5, 2, 2,  8'h21};
    vecs[1]  = '{1'b1, 1'b0, 8'h05, 4'd3,  8'h15, 2, 2,  8'h05};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 4'd0,  8'h40, 1, 3,  8'h40};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 4'd0,  8'h0A, 1, 4,  8'h02};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 4'd0,  8'h80, 1, 5,  8'h80};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 4'd0,  8'h0A, 1, 6,  8'h02};
    vecs[6]  = '{1'b1, 1'b1, 8'h05, 4'd3,  8'h80, 0, 0,  8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h01, 4'd0,  8'hFF, 8, 8,  8'hFF};
    vecs[8]  = '{1'b1, 1'b0, 8'hA5, 4'd15, 8'hA5, 1, 1,  8'h01};
    vecs[9]  = '{1'b1, 1'b0, 8'h01, 4'd1,  8'hFF, 8, 8,  8'hFF};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 4'd0,  8'hFF, 8, 15, 8'hFF};

    RESET = 1'b1; CFG_WE = 1'b0; CFG_PAT = '0; CFG_LEN = '0; IN_VALID = 1'b0; IN_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_in_ready", int'(IN_READY), 0);
    checkOutput("rst_hit", int'(HIT), 0);
    checkOutput("rst_done", int'(DONE), 0);
    checkOutput("rst_busy", int'(BUSY), 0);
    checkOutput("rst_total", int'(TOTAL_CNT), 0);
    checkOutput("rst_word_hits", int'(WORD_HITS), 0);
    RESET = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", int'(IN_READY), 1);
    @(posedge CLK); #1;

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
    IN_VALID = 1'b0;
    drainQueue();
    waitIdle();

    $display("[TB] mid-word reset sequence");
    IN_DATA  = 8'hFF;
    IN_VALID = 1'b1;
    waitHandshake(ok);
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    checkOutput("midrst_hit", int'(HIT), 0);
    checkOutput("midrst_done", int'(DONE), 0);
    checkOutput("midrst_busy", int'(BUSY), 0);
    checkOutput("midrst_total", int'(TOTAL_CNT), 0);
    checkOutput("midrst_in_ready", int'(IN_READY), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    checkOutput("midrst_release_ready", int'(IN_READY), 1);
    repeat (15) @(posedge CLK);
    #1;
    checkOutput("midrst_total_after", int'(TOTAL_CNT), 0);
    checkOutput("midrst_idle_after", int'(BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
